// File: rtl/shifter_right_seq_pkg.sv
// Shared definitions for the right-shift datapath and its sibling SLL shifter.
// Holds datapath widths, ALU function codes and the sequencer state encoding.
package shifter_right_seq_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned NUM_STAGES = SHAMT_W;

  // ALU function codes shared with the SLL shifter
  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_right_shift(input logic [5:0] code);
    return (code == SRL) || (code == SRA);
  endfunction

endpackage

// File: rtl/shifter_right_seq_stage.sv
// One log-shifter stage: shifts right by the single power of two selected
// by the one-hot amt_sel, filling vacated MSBs with fill.
// Ports:
//   in       word to shift
//   amt_sel  one-hot stage select (bit k => shift by 2^k)
//   en       apply the shift; when low the word passes through
//   fill     value for vacated MSBs
//   out      shifted word
module shift_right_stage
  import shifter_right_seq_pkg::*;
(
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] amt_sel,
  input  logic               en,
  input  logic               fill,
  output logic [WIDTH-1:0]   out
);

  localparam logic [WIDTH-1:0] ONES = '1;

  always_comb begin
    out = in;
    if (en) begin
      for (int unsigned k = 0; k < SHAMT_W; k++) begin
        if (amt_sel[k]) begin
          out = (in >> (32'd1 << k)) | ({WIDTH{fill}} & ~(ONES >> (32'd1 << k)));
        end
      end
    end
  end

endmodule

// File: rtl/shifter_right_seq.sv
// Multi-cycle logical/arithmetic right shifter. A start in IDLE captures the
// operands; five SHIFT cycles each apply one log-shifter stage; DONE then
// registers the result and pulses done one cycle later (fixed 6-cycle latency).
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start     request, honoured only in IDLE
//   dataA     value to shift
//   dataB     shift amount (bits above [4:0] must be zero for a valid op)
//   Signal    function code (SRL/SRA)
//   busy      high while in SHIFT or DONE
//   done      one-cycle pulse when dataOut is updated
//   dataOut   result, held until the next completed operation
module shifter_right_seq
  import shifter_right_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  state_t               state;
  state_t               state_next;
  logic [2:0]           stage;
  logic [SHAMT_W-1:0]   amt;
  logic [SHAMT_W-1:0]   stage_sel;
  logic [WIDTH-1:0]     work;
  logic [WIDTH-1:0]     shifted;
  logic [WIDTH-1:0]     data_out;
  logic                 sign;
  logic                 is_sra;
  logic                 valid;
  logic                 done_q;
  logic                 stage_last;

  assign stage_sel  = SHAMT_W'(1) << stage;
  assign stage_last = (stage == 3'(NUM_STAGES - 1));

  // Fill uses the captured sign of A rather than work[31] so the choice is
  // independent of how many stages have already been applied.
  shift_right_stage u_stage (
    .in      (work),
    .amt_sel (stage_sel),
    .en      (amt[stage]),
    .fill    (is_sra & sign),
    .out     (shifted)
  );

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (stage_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is registered with dataOut so the pulse coincides with the new
  // result; the FSM is already back in IDLE during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      stage    <= '0;
      amt      <= '0;
      work     <= '0;
      sign     <= 1'b0;
      is_sra   <= 1'b0;
      valid    <= 1'b0;
      done_q   <= 1'b0;
      data_out <= '0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            work   <= dataA;
            amt    <= dataB[SHAMT_W-1:0];
            sign   <= dataA[WIDTH-1];
            is_sra <= (Signal == SRA);
            valid  <= is_right_shift(Signal) && (dataB[WIDTH-1:SHAMT_W] == '0);
            stage  <= '0;
          end
        end
        SHIFT: begin
          work  <= shifted;
          stage <= stage + 3'd1;
        end
        DONE: begin
          data_out <= valid ? work : '0;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done    = done_q;
  assign dataOut = data_out;

endmodule

// File: tb/tb_shifter_right_seq.sv
module tb_shifter_right_seq;

  localparam logic [5:0] C_SRL = 6'b000010;
  localparam logic [5:0] C_SRA = 6'b000011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0]  Signal = '0;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  int checks = 0;
  int errors = 0;

  shifter_right_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] sig);
    logic signed [31:0] sa;
    logic [31:0]        r;
    sa = a;
    r  = '0;
    if ((sig == C_SRL || sig == C_SRA) && b[31:5] == 27'd0) begin
      if (sig == C_SRA) r = sa >>> b[4:0];
      else              r = a >> b[4:0];
    end
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model: an accepted start at edge c completes at edge c+6;
  // a new start is accepted from edge c+7 on.
  int          cyc = 0;
  bit          pend = 0;
  int          done_cyc = 0;
  logic [31:0] pend_res = '0;
  logic [31:0] exp_out = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend    = 0;
      exp_out = '0;
    end else begin
      if (pend && cyc == done_cyc) exp_out = pend_res;
      if (start && (!pend || cyc > done_cyc)) begin
        pend     = 1;
        done_cyc = cyc + 6;
        pend_res = ref_shift(dataA, dataB, Signal);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("cmp_busy", {31'd0, busy}, {31'd0, pend && cyc < done_cyc});
      chk("cmp_done", {31'd0, done}, {31'd0, pend && cyc == done_cyc});
      chk("cmp_dataOut", dataOut, exp_out);
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                        input logic [31:0] exp, input string name);
    int n;
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = sig;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd6);
    chk(name, dataOut, exp);
  endtask

  initial begin
    int pulses;
    logic [31:0] a, b;
    logic [5:0]  s;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dataOut", dataOut, 32'd0);
    rst = 1'b0;

    chk("model_sra31", ref_shift(32'h8000_0000, 32'd31, C_SRA), 32'hFFFF_FFFF);
    chk("model_srl31", ref_shift(32'h8000_0000, 32'd31, C_SRL), 32'h0000_0001);
    chk("model_bad_b", ref_shift(32'hFFFF_FFFF, 32'h20, C_SRL), 32'h0);

    run_op(32'hF000_0000, 32'd4, C_SRL, 32'h0F00_0000, "srl4");
    run_op(32'h8000_0000, 32'd31, C_SRA, 32'hFFFF_FFFF, "sra31");
    run_op(32'h8000_0000, 32'd31, C_SRL, 32'h0000_0001, "srl31");
    run_op(32'hFFFF_FFFF, 32'h20, C_SRL, 32'h0000_0000, "b_bit5");
    run_op(32'hFFFF_FFFF, 32'd3, 6'b000000, 32'h0000_0000, "bad_code");
    run_op(32'h1234_5678, 32'd0, C_SRA, 32'h1234_5678, "sra0");
    run_op(32'h8765_4321, 32'd12, C_SRA, 32'hFFF8_7654, "sra12");

    // start held high; operands change mid-op; second op accepted at t+7
    @(negedge clk);
    dataA  = 32'hF0F0_0000;
    dataB  = 32'd8;
    Signal = C_SRA;
    start  = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k == 2) begin
        dataA  = 32'h0000_FFFF;
        dataB  = 32'd1;
        Signal = C_SRL;
      end
      if (k == 6) begin
        chk("hold_first_done", {31'd0, done}, 32'd1);
        chk("hold_first_data", dataOut, 32'hFFF0_F000);
      end
      if (k == 7) begin
        chk("hold_second_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
      end
      if (k == 13) begin
        chk("hold_second_done", {31'd0, done}, 32'd1);
        chk("hold_second_data", dataOut, 32'h0000_7FFF);
      end
    end

    // reset at t+3 aborts the operation
    @(negedge clk);
    dataA  = 32'hFFFF_0000;
    dataB  = 32'd4;
    Signal = C_SRL;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_dataOut", dataOut, 32'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op(32'hFFFF_0000, 32'd4, C_SRL, 32'h0FFF_F000, "after_abort");

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = (i % 7 == 3) ? ($urandom | 32'h0000_0100) : 32'($urandom_range(0, 31));
      case (i % 3)
        0:       s = C_SRL;
        1:       s = C_SRA;
        default: s = (i % 9 == 2) ? 6'b000101 : C_SRA;
      endcase
      run_op(a, b, s, ref_shift(a, b, s), "sweep");
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
